// File: rtl/output_layer_mac.sv
`default_nettype none
// ============================================================================
// Module  : output_layer_mac
// Brief   : Streaming fully-connected output layer. Each accepted feature is
//           multiplied by one ROM weight row into N_OUT saturating accumulators.
// Revision: 1.0
// ============================================================================
module output_layer_mac #(
  parameter int N_IN     = 64,
  parameter int N_OUT    = 10,
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DATA_W-1:0]    in_data,
  output logic [$clog2(N_IN)-1:0]     w_addr,
  input  logic [N_OUT*WEIGHT_W-1:0]   w_row,
  output logic signed [ACC_W-1:0]     scores [N_OUT],
  output logic                        score_valid,
  output logic                        cmp_rst,
  output logic                        busy
);

  localparam int IDX_W  = $clog2(N_IN);
  localparam int PROD_W = DATA_W + WEIGHT_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [IDX_W-1:0]          r_index;
  logic signed [DATA_W-1:0]  r_x;
  logic                      r_pipe_valid;
  logic                      w_accept;
  logic                      w_last;

  assign w_last  = (r_index == IDX_W'(N_IN - 1));
  assign w_addr  = r_index;
  assign cmp_rst = ~score_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    score_valid = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: ;
      S_ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        // A start in the same cycle wins over the handshake; the data is dropped.
        w_accept = in_valid & ~start;
        if (w_accept && w_last) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        busy   = 1'b1;
        w_next = S_DONE;
      end
      S_DONE:  score_valid = 1'b1;
      default: w_next = S_IDLE;
    endcase
    if (start) w_next = S_ACCUM;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_index      <= '0;
      r_x          <= '0;
      r_pipe_valid <= 1'b0;
    end else begin
      r_pipe_valid <= w_accept;
      if (start) begin
        r_index <= '0;
      end else if (w_accept) begin
        r_x     <= in_data;
        r_index <= w_last ? '0 : r_index + IDX_W'(1);
      end
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_mac
    logic signed [WEIGHT_W-1:0] w_w;
    logic signed [PROD_W-1:0]   w_prod;
    logic signed [ACC_W:0]      w_sum;
    logic signed [ACC_W-1:0]    w_sat;
    logic signed [ACC_W-1:0]    r_acc;

    assign w_w    = w_row[j*WEIGHT_W +: WEIGHT_W];
    assign w_prod = PROD_W'(r_x) * PROD_W'(w_w);
    assign w_sum  = {r_acc[ACC_W-1], r_acc}
                  + {{(ACC_W + 1 - PROD_W){w_prod[PROD_W-1]}}, w_prod};

    // One guard bit: a disagreement with the sign bit means the sum left range.
    always_comb begin
      w_sat = w_sum[ACC_W-1:0];
      if (w_sum[ACC_W] != w_sum[ACC_W-1])
        w_sat = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)              r_acc <= '0;
      else if (start)        r_acc <= '0;
      else if (r_pipe_valid) r_acc <= w_sat;
    end

    assign scores[j] = r_acc;
  end

endmodule
`default_nettype wire

// File: tb/tb_output_layer_mac.sv
`default_nettype none
// ============================================================================
// Module  : tb_output_layer_mac
// Brief   : Self-checking bench for output_layer_mac with a saturating
//           dot-product reference model and a synchronous weight ROM.
// Revision: 1.0
// ============================================================================
module tb_output_layer_mac;

  localparam int N_IN     = 4;
  localparam int N_OUT    = 10;
  localparam int DATA_W   = 8;
  localparam int WEIGHT_W = 8;
  localparam int ACC_W    = 16;

  logic                           clk = 1'b0;
  logic                           rst;
  logic                           start;
  logic                           in_valid;
  logic                           in_ready;
  logic signed [DATA_W-1:0]       in_data;
  logic [$clog2(N_IN)-1:0]        w_addr;
  logic [N_OUT*WEIGHT_W-1:0]      w_row;
  logic signed [ACC_W-1:0]        scores [N_OUT];
  logic                           score_valid;
  logic                           cmp_rst;
  logic                           busy;

  int tests = 0;
  int fails = 0;

  logic signed [WEIGHT_W-1:0] rom [N_IN][N_OUT];
  longint                     exp_s [N_OUT];
  bit                         vpat [$];
  bit                         rnd_valid;

  typedef struct {
    logic [N_IN-1:0][DATA_W-1:0] x;
    int                          e3;
    int                          eo;
  } vec_t;

  output_layer_mac #(
    .N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .w_addr(w_addr), .w_row(w_row), .scores(scores),
    .score_valid(score_valid), .cmp_rst(cmp_rst), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: row appears one cycle after its address.
  always @(posedge clk)
    for (int j = 0; j < N_OUT; j++) w_row[j*WEIGHT_W +: WEIGHT_W] <= rom[w_addr][j];

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic rom_set(input int kind);
    for (int i = 0; i < N_IN; i++)
      for (int j = 0; j < N_OUT; j++)
        case (kind)
          0:       rom[i][j] = (j == 3) ? 8'sd2 : 8'sd1;
          1:       rom[i][j] = 8'sd127;
          default: rom[i][j] = WEIGHT_W'($urandom_range(0, 255));
        endcase
  endtask

  // Sequential saturating dot product per class.
  function automatic void model(input logic [N_IN-1:0][DATA_W-1:0] xs);
    longint hi;
    longint lo;
    longint a;
    hi = (longint'(1) <<< (ACC_W - 1)) - 1;
    lo = -(longint'(1) <<< (ACC_W - 1));
    for (int j = 0; j < N_OUT; j++) begin
      a = 0;
      for (int i = 0; i < N_IN; i++) begin
        a = a + longint'($signed(xs[i])) * longint'(rom[i][j]);
        if (a > hi) a = hi;
        if (a < lo) a = lo;
      end
      exp_s[j] = a;
    end
  endfunction

  task automatic start_pulse(input string tag);
    start    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_start_ready"}, in_ready, 1);
    chk({tag, "_start_sv"}, score_valid, 0);
    chk({tag, "_start_cmprst"}, cmp_rst, 1);
  endtask

  // Feeds all features (honouring vpat / random valid), then checks latency and scores.
  task automatic run_inf(input logic [N_IN-1:0][DATA_W-1:0] xs, input string tag);
    int n   = 0;
    int cyc = 0;
    bit acc;
    model(xs);
    while (n < N_IN && cyc < 100) begin
      chk({tag, "_waddr"}, w_addr, n);
      if (vpat.size() > 0) in_valid = vpat.pop_front();
      else if (rnd_valid)  in_valid = ($urandom_range(0, 3) != 0);
      else                 in_valid = 1'b1;
      in_data = xs[n];
      acc = in_valid && in_ready;
      @(posedge clk);
      @(negedge clk);
      if (acc) n++;
      cyc++;
    end
    in_valid = 1'b0;
    if (n < N_IN) chk({tag, "_timeout_accepts"}, n, N_IN);
    chk({tag, "_sv_early"}, score_valid, 0);
    chk({tag, "_flush_busy"}, busy, 1);
    chk({tag, "_flush_ready"}, in_ready, 0);
    @(negedge clk);
    chk({tag, "_sv_rise"}, score_valid, 1);
    chk({tag, "_cmprst_low"}, cmp_rst, 0);
    chk({tag, "_done_busy"}, busy, 0);
    for (int j = 0; j < N_OUT; j++)
      chk($sformatf("%s_score%0d", tag, j), scores[j], exp_s[j]);
  endtask

  task automatic chk_const(input string tag, input int e3, input int eo);
    for (int j = 0; j < N_OUT; j++)
      chk($sformatf("%s_const%0d", tag, j), scores[j], (j == 3) ? e3 : eo);
  endtask

  initial begin
    vec_t tbl [4];
    logic [N_IN-1:0][DATA_W-1:0] xs;

    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; rnd_valid = 1'b0;
    rom_set(0);

    tbl[0].x = {8'd4, 8'd3, 8'd2, 8'd1};         tbl[0].e3 = 20;  tbl[0].eo = 10;
    tbl[1].x = {8'd1, 8'd1, 8'd1, 8'd1};         tbl[1].e3 = 8;   tbl[1].eo = 4;
    tbl[2].x = {8'hFC, 8'hFD, 8'hFE, 8'hFF};     tbl[2].e3 = -20; tbl[2].eo = -10;
    tbl[3].x = {8'd7, 8'hFB, 8'd0, 8'd10};       tbl[3].e3 = 24;  tbl[3].eo = 12;

    #2;
    chk("rst_ready", in_ready, 0);
    chk("rst_sv", score_valid, 0);
    chk("rst_cmprst", cmp_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_waddr", w_addr, 0);
    chk("rst_score0", scores[0], 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    for (int k = 0; k < 4; k++) begin
      start_pulse("tbl");
      run_inf(tbl[k].x, $sformatf("tbl%0d", k));
      chk_const($sformatf("tbl%0d", k), tbl[k].e3, tbl[k].eo);
    end

    // Backpressure: same result, address frozen while stalled.
    vpat = '{1, 0, 0, 1, 1, 0, 1};
    start_pulse("stall");
    run_inf(tbl[0].x, "stall");
    chk_const("stall", 20, 10);

    // Saturation at both rails.
    rom_set(1);
    start_pulse("sat");
    run_inf({4{8'd127}}, "sat_hi");
    chk_const("sat_hi", 32767, 32767);
    start_pulse("sat");
    run_inf({4{8'h80}}, "sat_lo");
    chk_const("sat_lo", -32768, -32768);

    // Abort after two accepts; start collides with an offered feature.
    rom_set(0);
    start_pulse("abort");
    in_valid = 1'b1; in_data = 8'sd5;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    start = 1'b1; in_data = 8'sd100;
    @(posedge clk); @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    chk("abort_waddr", w_addr, 0);
    chk("abort_busy", busy, 1);
    run_inf(tbl[1].x, "abort");
    chk_const("abort", 8, 4);

    // Asynchronous reset while in FLUSH.
    start_pulse("rstflush");
    in_valid = 1'b1; in_data = 8'sd3;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    in_valid = 1'b0;
    chk("rstflush_busy", busy, 1);
    chk("rstflush_ready", in_ready, 0);
    #2 rst = 1'b0;
    #1;
    for (int j = 0; j < N_OUT; j++) chk($sformatf("rstflush_score%0d", j), scores[j], 0);
    chk("rstflush_sv", score_valid, 0);
    chk("rstflush_cmprst", cmp_rst, 1);
    chk("rstflush_ready0", in_ready, 0);
    chk("rstflush_busy0", busy, 0);
    chk("rstflush_waddr", w_addr, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start_pulse("postrst");
    run_inf(tbl[0].x, "postrst");
    chk_const("postrst", 20, 10);

    // in_valid in DONE is ignored, then restart from DONE.
    in_valid = 1'b1; in_data = 8'sd50;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    in_valid = 1'b0;
    chk("done_hold_sv", score_valid, 1);
    chk("done_hold_waddr", w_addr, 0);
    chk("done_hold_s3", scores[3], 20);
    chk("done_hold_s0", scores[0], 10);
    start_pulse("restart");
    run_inf(tbl[3].x, "restart");
    chk_const("restart", 24, 12);

    // Randomized weights, features and valid pattern against the model.
    rnd_valid = 1'b1;
    for (int r = 0; r < 25; r++) begin
      rom_set(2);
      for (int i = 0; i < N_IN; i++) xs[i] = DATA_W'($urandom_range(0, 255));
      start_pulse("rnd");
      run_inf(xs, $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
